// File: rtl/reg_wb_pkg.sv
// Shared types and constants for the register writeback queue.
// Latency: none (declarations only).
// Backpressure: not applicable.
package reg_wb_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    // Register 0 is hardwired to zero; writes to it are dropped.
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of writeback entries; exposes storage and valid bits for lookup.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: pushes are ignored when full and pops are ignored when empty.
module wb_fifo
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = ADDR_W + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  wb_entry_t                push_entry,
    input  logic                     pop,
    output logic [CNT_W-1:0]         count,
    output logic [$clog2(DEPTH)-1:0] rd_ptr,
    output wb_entry_t [DEPTH-1:0]    entries,
    output logic [DEPTH-1:0]         valid
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow and underflow so the pointers stay consistent.
    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);

    // Pointers, occupancy, storage and valid bits; pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            valid   <= '0;
            entries <= '0;
        end else begin
            if (do_push) begin
                entries[wr_ptr] <= push_entry;
                valid[wr_ptr]   <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_wb_queue.sv
// Buffers register writebacks, drains one per cycle to the RF write port, scoreboards RS/RT.
// Latency: accepted at edge N into an empty queue -> on the RF port in cycle N+1.
// Backpressure: wb_ready low when full (no pass-through); drain gated by rf_wr_allow.
// Optional build macro REG_WB_FWD_EN adds youngest-entry data forwarding to rs/rt_fwd_data.
module reg_wb_queue
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              rf_wr_allow,
    output logic              rf_rw,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_data,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              rs_pending,
    output logic              rt_pending,
    output logic [DATA_W-1:0] rs_fwd_data,
    output logic [DATA_W-1:0] rt_fwd_data,
    output logic [ADDR_W:0]   count
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int PTR_W = $clog2(DEPTH);

    logic                  push_go;
    logic [CNT_W-1:0]      occ;
    logic [PTR_W-1:0]      rd_ptr;
    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      valid;
    wb_entry_t             push_entry;
    wb_entry_t             head;
    logic                  not_empty;

    // Ready is forced low during reset; writes to register 0 complete the handshake but are dropped.
    assign wb_ready   = !reset && (occ != CNT_W'(DEPTH));
    assign push_go    = wb_valid && wb_ready && (wb_rd != REG_ZERO);
    assign push_entry = '{rd: wb_rd, data: wb_data};

    wb_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_go),
        .push_entry (push_entry),
        .pop        (rf_rw),
        .count      (occ),
        .rd_ptr     (rd_ptr),
        .entries    (entries),
        .valid      (valid)
    );

    // Head drives the RF port directly; zeroed when empty so idle cycles show clean values.
    assign head      = entries[rd_ptr];
    assign not_empty = (occ != '0);
    assign rf_rw     = not_empty && rf_wr_allow;
    assign rf_rd     = not_empty ? head.rd   : REG_ZERO;
    assign rf_data   = not_empty ? head.data : '0;
    assign count     = occ;

    // Pending flags: any live entry targeting the operand, the head included while it drains.
    always_comb begin
        rs_pending = 1'b0;
        rt_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entries[i].rd == rs_addr) && (rs_addr != REG_ZERO)) begin
                rs_pending = 1'b1;
            end
            if (valid[i] && (entries[i].rd == rt_addr) && (rt_addr != REG_ZERO)) begin
                rt_pending = 1'b1;
            end
        end
    end

`ifdef REG_WB_FWD_EN
    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest from the head so the last match is the youngest write.
    always_comb begin
        rs_fwd_data = '0;
        rt_fwd_data = '0;
        idx         = rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (valid[idx] && (entries[idx].rd == rs_addr) && (rs_addr != REG_ZERO)) begin
                rs_fwd_data = entries[idx].data;
            end
            if (valid[idx] && (entries[idx].rd == rt_addr) && (rt_addr != REG_ZERO)) begin
                rt_fwd_data = entries[idx].data;
            end
        end
    end
`else
    // Without forwarding the core stalls on the pending flags instead.
    assign rs_fwd_data = '0;
    assign rt_fwd_data = '0;
`endif

endmodule
